// File: rtl/param_ram_pkg.sv
// Shared definitions for the param_ram data memory: port FSM state encodings
// and the wait-counter width used by both handshake ports.
package param_ram_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } port_state_e;

endpackage

// File: rtl/ram_port_fsm.sv
// One handshake port of param_ram: edge-armed request capture, range check,
// wait-state counter and registered rdy/exc generation.
module ram_port_fsm
    import param_ram_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              req,
    output logic              fire,
    output logic [IDX_W-1:0]  idx,
    output logic              rdy,
    output logic              exc
);

    localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    port_state_e      state;
    port_state_e      state_nxt;
    logic             req_q;
    logic             oor_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             in_range;
    logic             busy_last;

    // Full-width compare so that addresses above DEPTH never alias into the array.
    assign in_range  = ({1'b0, addr} < DEPTH_X);
    assign accept    = req && !req_q && (state != ST_BUSY);
    assign busy_last = (state == ST_BUSY) && (oor_q || (cnt == ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)    state_nxt = ST_BUSY;
            ST_BUSY: if (busy_last) state_nxt = ST_DONE;
            ST_DONE: if (accept)    state_nxt = ST_BUSY;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rdy  = (state != ST_BUSY);
        // Gated by rst so an access interrupted by reset never commits.
        fire = (state == ST_BUSY) && !oor_q && (cnt == ONE) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
            oor_q <= 1'b0;
            cnt   <= '0;
            exc   <= 1'b0;
        end else begin
            req_q <= req;
            if (accept) begin
                exc   <= 1'b0;
                oor_q <= !in_range;
                cnt   <= in_range ? LAT_CNT : '0;
            end else if (state == ST_BUSY) begin
                if (oor_q) begin
                    exc <= 1'b1;
                end else begin
                    cnt <= cnt - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx <= addr[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/param_ram.sv
// Parametrised single-clock data RAM with independent read and write
// handshake ports, byte-lane writes, range exceptions and write-first bypass.
module param_ram
    import param_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   r_addr,
    input  logic                read,
    output logic [DATA_W-1:0]   r_line,
    output logic                r_rdy,
    output logic                r_exc,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_line,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic                write,
    output logic                w_rdy,
    output logic                w_exc
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] w_data_q;
    logic [LANES-1:0]  w_be_q;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx;
    logic              r_fire;
    logic              w_fire;

    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    ram_port_fsm #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .IDX_W   (IDX_W)
    ) u_rd_port (
        .clk  (clk),
        .rst  (rst),
        .addr (r_addr),
        .req  (read),
        .fire (r_fire),
        .idx  (r_idx),
        .rdy  (r_rdy),
        .exc  (r_exc)
    );

    ram_port_fsm #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .IDX_W   (IDX_W)
    ) u_wr_port (
        .clk  (clk),
        .rst  (rst),
        .addr (w_addr),
        .req  (write),
        .fire (w_fire),
        .idx  (w_idx),
        .rdy  (w_rdy),
        .exc  (w_exc)
    );

    // Tracking the inputs whenever the port is not busy leaves the accept-edge
    // values frozen for the whole access.
    always_ff @(posedge clk) begin
        if (w_rdy) begin
            w_data_q <= w_line;
            w_be_q   <= w_be;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            mem[w_idx] <= merge_lanes(mem[w_idx], w_data_q, w_be_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
        end else if (r_fire) begin
            if (w_fire && (w_idx == r_idx)) begin
                r_line <= merge_lanes(mem[r_idx], w_data_q, w_be_q);
            end else begin
                r_line <= mem[r_idx];
            end
        end
    end

endmodule
